vga_scan_gen: RTL and testbench

VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_scan_gen_if.sv | 21 ++
 rtl/pixel_tick_gen.sv | 44 ++++
 rtl/vga_scan_gen.sv | 144 ++++++++++++++
 tb/tb_vga_scan_gen.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg: default 640x480@60 timing, derived totals, coordinate type   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package vga_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = (1 << COORD_W) - 1;

  typedef logic [COORD_W-1:0] coord_t;

  // Half-open window test lo <= c < hi on a zero-extended coordinate.
  function automatic logic in_window(coord_t c, int lo, int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_scan_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_scan_gen_if: scan timing outputs bundled for a video consumer     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface vga_scan_gen_if;
  import vga_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   p_tick;
  logic   frame_start;
  coord_t x;
  coord_t y;

  modport master (output hsync, vsync, video_on, p_tick, frame_start, x, y);
  modport slave  (input  hsync, vsync, video_on, p_tick, frame_start, x, y);

endinterface
`default_nettype wire

// File: rtl/pixel_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pixel_tick_gen: divides clk by CLK_DIV, one-clk p_tick per pixel      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("pixel_tick_gen: CLK_DIV must be at least 2");
    end
  endgenerate

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign p_tick = (div_q == DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/vga_scan_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_scan_gen: VGA h/v scan counters with sync, blanking, coordinates  |
// | Option macro VGA_SYNC_REG_EN registers all decodes one pixel late.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int CLK_DIV   = 4
) (
  input  logic           clk,
  input  logic           reset,
  vga_scan_gen_if.master vga
);

  localparam int     H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int     V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);

  generate
    if ((H_TOTAL > COORD_MAX) || (V_TOTAL > COORD_MAX)) begin : g_bad_total
      $error("vga_scan_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
    end
  endgenerate

  logic   p_tick;
  coord_t h_q, h_d;
  coord_t v_q, v_d;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (p_tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + coord_t'(1);
      end else begin
        h_d = h_q + coord_t'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  logic hsync_dec;
  logic vsync_dec;
  logic video_dec;
  logic origin;

  assign hsync_dec = !in_window(h_q, H_DISPLAY + H_FRONT, H_DISPLAY + H_FRONT + H_SYNC);
  assign vsync_dec = !in_window(v_q, V_DISPLAY + V_FRONT, V_DISPLAY + V_FRONT + V_SYNC);
  assign video_dec = in_window(h_q, 0, H_DISPLAY) && in_window(v_q, 0, V_DISPLAY);
  assign origin    = (h_q == '0) && (v_q == '0);

  assign vga.p_tick = p_tick;

`ifdef VGA_SYNC_REG_EN
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   video_on_q, video_on_d;
  logic   origin_q, origin_d;
  coord_t x_q, x_d;
  coord_t y_q, y_d;

  // Capture the decode of the pixel being left, so all outputs trail the counters by one pixel.
  always_comb begin
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    video_on_d = video_on_q;
    origin_d   = origin_q;
    x_d        = x_q;
    y_d        = y_q;
    if (p_tick) begin
      hsync_d    = hsync_dec;
      vsync_d    = vsync_dec;
      video_on_d = video_dec;
      origin_d   = origin;
      x_d        = h_q;
      y_d        = v_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
      origin_q   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
      origin_q   <= origin_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.frame_start = p_tick && origin_q;
`else
  // Counters sit at the origin during reset, so blanking must be forced explicitly.
  assign vga.hsync       = hsync_dec;
  assign vga.vsync       = vsync_dec;
  assign vga.video_on    = video_dec && !reset;
  assign vga.x           = h_q;
  assign vga.y           = v_q;
  assign vga.frame_start = p_tick && origin;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_scan_gen: directed checks on a reduced-timing and a default DUT |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_vga_scan_gen;
  import vga_pkg::*;

`ifdef VGA_SYNC_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  localparam int SHD = 16, SHF = 4, SHS = 6, SHB = 4, SHT = 30;
  localparam int SVD = 8,  SVF = 2, SVS = 2, SVB = 3, SVT = 15;
  localparam int DIV = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_scan_gen_if if_s ();
  vga_scan_gen_if if_d ();

  vga_scan_gen #(
    .H_DISPLAY (SHD), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
    .V_DISPLAY (SVD), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
    .CLK_DIV   (DIV)
  ) u_small (
    .clk   (clk),
    .reset (reset),
    .vga   (if_s)
  );

  vga_scan_gen u_dflt (
    .clk   (clk),
    .reset (reset),
    .vga   (if_d)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n      = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(string p, logic [9:0] ox, logic [9:0] oy, logic ohs, logic ovs,
                         logic ovo, logic opt, logic ofs);
    chk({p, ".x"},           32'(ox),  0);
    chk({p, ".y"},           32'(oy),  0);
    chk({p, ".hsync"},       32'(ohs), 1);
    chk({p, ".vsync"},       32'(ovs), 1);
    chk({p, ".video_on"},    32'(ovo), 0);
    chk({p, ".p_tick"},      32'(opt), 0);
    chk({p, ".frame_start"}, 32'(ofs), 0);
  endtask

  // Expected outputs at pixel index idx counted from the first p_tick after reset.
  task automatic chk_pix(string p, int idx, int hd, int hf, int hs, int ht,
                         int vd, int vf, int vs, int vt,
                         logic [9:0] ox, logic [9:0] oy, logic ohs, logic ovs,
                         logic ovo, logic ofs);
    int k, ex, ey;
    logic ehs, evs, evo, efs;
    k = idx - LAT;
    if (k < 0) begin
      ex = 0; ey = 0; ehs = 1'b1; evs = 1'b1; evo = 1'b0; efs = 1'b0;
    end else begin
      ex  = k % ht;
      ey  = (k / ht) % vt;
      ehs = !((ex >= hd + hf) && (ex < hd + hf + hs));
      evs = !((ey >= vd + vf) && (ey < vd + vf + vs));
      evo = (ex < hd) && (ey < vd);
      efs = (ex == 0) && (ey == 0);
    end
    chk({p, ".x"},           32'(ox),  ex);
    chk({p, ".y"},           32'(oy),  ey);
    chk({p, ".hsync"},       32'(ohs), 32'(ehs));
    chk({p, ".vsync"},       32'(ovs), 32'(evs));
    chk({p, ".video_on"},    32'(ovo), 32'(evo));
    chk({p, ".frame_start"}, 32'(ofs), 32'(efs));
  endtask

  task automatic chk_both();
    chk_pix("s", n, SHD, SHF, SHS, SHT, SVD, SVF, SVS, SVT,
            if_s.x, if_s.y, if_s.hsync, if_s.vsync, if_s.video_on, if_s.frame_start);
    chk_pix("d", n, H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_TOTAL_DEF,
            V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_TOTAL_DEF,
            if_d.x, if_d.y, if_d.hsync, if_d.vsync, if_d.video_on, if_d.frame_start);
  endtask

  // Advance to the next p_tick sample point; the gap must be exactly DIV clocks.
  task automatic step_pix();
    int clks;
    clks = 0;
    do begin
      @(negedge clk);
      #1;
      clks++;
    end while (!if_s.p_tick && clks < 2 * DIV);
    n++;
    chk("tick_period", clks, DIV);
    chk("tick_align", 32'(if_d.p_tick), 1);
    chk("tick_one_clk_fs", 32'(if_s.frame_start && !if_s.p_tick), 0);
  endtask

  // Entered with reset high: checks reset values, releases reset, checks first pixel.
  task automatic restart_check(string p);
    chk_rst({p, ".s"}, if_s.x, if_s.y, if_s.hsync, if_s.vsync, if_s.video_on,
            if_s.p_tick, if_s.frame_start);
    chk_rst({p, ".d"}, if_d.x, if_d.y, if_d.hsync, if_d.vsync, if_d.video_on,
            if_d.p_tick, if_d.frame_start);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 1; i <= DIV; i++) begin
      chk({p, ".first_tick"}, 32'(if_s.p_tick), 32'(i == DIV));
      if (i < DIV) begin
        @(negedge clk);
        #1;
      end
    end
    n = 0;
    chk_both();
  endtask

  int   d_low = 0, d_fall_n = -1, d_fall_x = -1, d_rise_x = -1;
  int   s_vlow = 0, s_vfall_y = -1, s_fs = 0, s_fs_n = -1;
  logic prev_dhs = 1'b1;
  logic prev_svs = 1'b1;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    restart_check("por");

    // Two small frames, which also span the first full default line.
    for (int i = 0; i < 2 * SHT * SVT + 1; i++) begin
      step_pix();
      chk_both();
      if ((n - LAT) >= 0 && (n - LAT) < H_TOTAL_DEF && !if_d.hsync) d_low++;
      if (prev_dhs && !if_d.hsync && d_fall_n < 0) begin
        d_fall_n = n;
        d_fall_x = int'(if_d.x);
      end
      if (!prev_dhs && if_d.hsync && d_rise_x < 0) d_rise_x = int'(if_d.x);
      prev_dhs = if_d.hsync;
      if (!if_s.vsync) s_vlow++;
      if (prev_svs && !if_s.vsync && s_vfall_y < 0) s_vfall_y = int'(if_s.y);
      prev_svs = if_s.vsync;
      if (if_s.frame_start) begin
        s_fs++;
        if (s_fs_n < 0) s_fs_n = n;
      end
    end

    chk("d_hs_low_pixels", d_low,    96);
    chk("d_hs_fall_x",     d_fall_x, 656);
    chk("d_hs_fall_index", d_fall_n, 656 + LAT);
    chk("d_hs_rise_x",     d_rise_x, 752);
    chk("s_vs_low_pixels", s_vlow,   2 * SVS * SHT);
    chk("s_vs_fall_y",     s_vfall_y, 10);
    chk("s_frame_count",   s_fs,     2);
    chk("s_frame_index",   s_fs_n,   SHT * SVT + LAT);

    // Run to (10,5) on the small DUT, then hit reset mid-line off the clock edge.
    for (int i = 0; i < SHT * SVT && ((n - LAT) % (SHT * SVT)) != (5 * SHT + 10); i++) begin
      step_pix();
      chk_both();
    end
    chk("pre_rst_x", 32'(if_s.x), 10);
    chk("pre_rst_y", 32'(if_s.y), 5);
    #2;
    reset = 1'b1;
    #1;
    chk_rst("async.s", if_s.x, if_s.y, if_s.hsync, if_s.vsync, if_s.video_on,
            if_s.p_tick, if_s.frame_start);
    repeat (3) @(posedge clk);
    #1;
    restart_check("mid");

    for (int i = 0; i < 2 * SHT; i++) begin
      step_pix();
      chk_both();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
